// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one synchronous single-port RAM between the
//                instruction-fetch stage and the MEM stage. Grants at most
//                one access per cycle. Read data returns to the owner one
//                cycle later. Data wins ties, but IF is forced through after
//                MAX_D_BURST consecutive data grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 21,
    parameter int MAX_D_BURST    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_jump_i,
    input  logic                      if_req_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic [DATA_WIDTH-1:0]     if_inst_o,
    output logic                      if_valid_o,
    input  logic                      d_req_i,
    input  logic                      d_we_i,
    input  logic [3:0]                d_be_i,
    input  logic [ADDR_WIDTH-1:0]     d_addr_i,
    input  logic [DATA_WIDTH-1:0]     d_wdata_i,
    output logic [DATA_WIDTH-1:0]     d_rdata_o,
    output logic                      d_valid_o,
    output logic                      stallreq_if_o,
    output logic                      stallreq_mem_o,
    output logic                      ram_ce_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam logic [3:0] c_max_burst = 4'(MAX_D_BURST);

    logic                  r_if_issued;
    logic                  r_d_issued;
    logic                  r_resp_valid;
    logic                  r_resp_if;
    logic                  r_resp_we;
    logic [3:0]            r_burst_cnt;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_if_ret;
    logic w_d_ret;
    logic w_if_valid;
    logic w_d_rd_ret;
    logic w_if_cand;
    logic w_d_cand;
    logic w_if_grant;
    logic w_d_grant;

    // Upper address bits are intentionally dropped before the RAM.
    wire w_unused = &{1'b0, if_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                      d_addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};

    // Response decode; a flush squashes the IF return in the same cycle.
    assign w_if_ret   = r_resp_valid & r_resp_if;
    assign w_d_ret    = r_resp_valid & ~r_resp_if;
    assign w_if_valid = w_if_ret & ~flush_jump_i;
    assign w_d_rd_ret = w_d_ret & ~r_resp_we;

    // Candidates: a returning access clears its issued flag in the same cycle,
    // so back-to-back grants to one requester are possible.
    assign w_if_cand = if_req_i & ~(r_if_issued & ~w_if_ret) & ~flush_jump_i & ~rst_i;
    assign w_d_cand  = d_req_i & ~(r_d_issued & ~w_d_ret) & ~rst_i;

    // Data wins ties unless it has used up its burst allowance.
    assign w_if_grant = w_if_cand & (~w_d_cand | (r_burst_cnt == c_max_burst));
    assign w_d_grant  = w_d_cand & ~w_if_grant;

    // RAM strobes come from the winner; everything is zero when idle.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (w_d_grant) begin
            ram_ce_o    = 1'b1;
            ram_we_o    = d_we_i;
            ram_be_o    = d_be_i;
            ram_addr_o  = d_addr_i[RAM_ADDR_WIDTH-1:0];
            ram_wdata_o = d_wdata_i;
        end else if (w_if_grant) begin
            ram_ce_o    = 1'b1;
            ram_addr_o  = if_addr_i[RAM_ADDR_WIDTH-1:0];
        end
    end

    // Read data is passed straight through on return and held afterwards.
    assign if_inst_o      = w_if_valid ? ram_rdata_i : r_if_inst;
    assign if_valid_o     = w_if_valid;
    assign d_rdata_o      = w_d_rd_ret ? ram_rdata_i : r_d_rdata;
    assign d_valid_o      = w_d_ret;
    assign stallreq_if_o  = if_req_i & ~if_valid_o;
    assign stallreq_mem_o = d_req_i & ~d_valid_o;

    // Issued flags: set on grant, cleared on return (or flush for IF).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_if_issued <= 1'b0;
            r_d_issued  <= 1'b0;
        end else begin
            if (w_if_grant)
                r_if_issued <= 1'b1;
            else if (w_if_ret || flush_jump_i)
                r_if_issued <= 1'b0;
            if (w_d_grant)
                r_d_issued <= 1'b1;
            else if (w_d_ret)
                r_d_issued <= 1'b0;
        end
    end

    // Count data grants that starved a waiting IF request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_burst_cnt <= 4'd0;
        end else if (w_if_grant || !if_req_i) begin
            r_burst_cnt <= 4'd0;
        end else if (w_d_grant && w_if_cand && (r_burst_cnt != c_max_burst)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    // Response stage: remember who owns the RAM data arriving next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_if    <= 1'b0;
            r_resp_we    <= 1'b0;
        end else begin
            r_resp_valid <= w_if_grant | w_d_grant;
            r_resp_if    <= w_if_grant;
            r_resp_we    <= w_d_grant & d_we_i;
        end
    end

    // Hold the last returned words so outputs stay stable between returns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_if_inst <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_if_valid)
                r_if_inst <= ram_rdata_i;
            if (w_d_rd_ret)
                r_d_rdata <= ram_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a behavioural
//                synchronous RAM and per-requester expected-data queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_jump_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [20:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] last_if;
    logic [31:0] last_d;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(21), .MAX_D_BURST(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_jump_i(flush_jump_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
        .if_valid_o(if_valid_o), .d_req_i(d_req_i), .d_we_i(d_we_i),
        .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // Behavioural synchronous RAM: byte-enabled write, registered read.
    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        mem[0]    = 32'h0000_0013;
        mem[64]   = 32'hDEAD_BEEF;
        mem[128]  = 32'h1122_3344;
        ram_rdata_i = 32'h0;
        forever begin
            @(posedge clk_i);
            if (ram_ce_o && ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b])
                        mem[ram_addr_o[11:2]][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
            end else if (ram_ce_o) begin
                ram_rdata_i <= mem[ram_addr_o[11:2]];
            end
        end
    end

    // Scoreboard: every valid pulse consumes one expected value.
    always @(negedge clk_i) begin
        if (if_valid_o) begin
            if (if_q.size() == 0) check("if_extra_valid", 32'(if_valid_o), 32'h0);
            else check("if_data", if_inst_o, if_q.pop_front());
        end
        if (d_valid_o) begin
            if (d_q.size() == 0) check("d_extra_valid", 32'(d_valid_o), 32'h0);
            else check("d_data", d_rdata_o, d_q.pop_front());
        end
    end

    initial begin
        rst_i = 1'b1; flush_jump_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = 32'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;

        // Reset state
        repeat (3) tick();
        check("rst_if_valid", 32'(if_valid_o), 32'h0);
        check("rst_d_valid",  32'(d_valid_o), 32'h0);
        check("rst_if_inst",  if_inst_o, 32'h0);
        check("rst_d_rdata",  d_rdata_o, 32'h0);
        check("rst_stall",    32'({stallreq_if_o, stallreq_mem_o}), 32'h0);
        check("rst_ram_ce",   32'(ram_ce_o), 32'h0);
        check("rst_burst",    32'(dut.r_burst_cnt), 32'h0);
        rst_i = 1'b0;

        // IF only, then a held request re-reads the same word
        tick(); if_req_i = 1'b1; if_addr_i = 32'h0; if_q.push_back(32'h13);
        sample();
        check("ifo_ce",      32'(ram_ce_o), 32'h1);
        check("ifo_addr",    32'(ram_addr_o), 32'h0);
        check("ifo_we",      32'(ram_we_o), 32'h0);
        check("ifo_stall0",  32'(stallreq_if_o), 32'h1);
        check("ifo_valid0",  32'(if_valid_o), 32'h0);
        tick(); if_q.push_back(32'h13);
        sample();
        check("ifo_valid1",  32'(if_valid_o), 32'h1);
        check("ifo_stall1",  32'(stallreq_if_o), 32'h0);
        check("ifo_regrant", 32'(ram_ce_o), 32'h1);
        tick(); if_req_i = 1'b0;
        sample();
        tick(); sample();
        check("ifo_idle",    32'(if_valid_o), 32'h0);
        last_if = 32'h13;

        // Conflict: data wins the tie, IF follows
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h4;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
        d_q.push_back(32'hDEAD_BEEF); if_q.push_back(mem[1]);
        sample();
        check("cf_addr_d",    32'(ram_addr_o), 32'h100);
        check("cf_stall_mem", 32'(stallreq_mem_o), 32'h1);
        check("cf_stall_if",  32'(stallreq_if_o), 32'h1);
        tick(); d_req_i = 1'b0;
        sample();
        check("cf_d_valid",   32'(d_valid_o), 32'h1);
        check("cf_addr_if",   32'(ram_addr_o), 32'h4);
        check("cf_ce_if",     32'(ram_ce_o), 32'h1);
        tick(); if_req_i = 1'b0;
        sample();
        check("cf_if_valid",  32'(if_valid_o), 32'h1);
        last_if = mem[1]; last_d = 32'hDEAD_BEEF;
        tick(); sample();

        // Starvation: four data grants, then IF is forced through
        for (int k = 0; k < 6; k++) begin
            tick();
            if_req_i = (k < 5); if_addr_i = 32'h8;
            d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40 + 32'(4 * k);
            if (k == 4) if_q.push_back(mem[2]);
            else d_q.push_back(mem[16 + k]);
            sample();
            if (k == 4) begin
                check("st_if_grant", 32'(ram_addr_o), 32'h8);
                check("st_burst_max", 32'(dut.r_burst_cnt), 32'h4);
            end else begin
                check("st_d_grant", 32'(ram_addr_o), 32'h40 + 32'(4 * k));
            end
            if (k == 5) check("st_burst_clr", 32'(dut.r_burst_cnt), 32'h0);
        end
        tick(); d_req_i = 1'b0; if_req_i = 1'b0;
        sample();
        tick(); sample();
        last_d = mem[21]; last_if = mem[2];

        // Write with partial byte enables, then read back
        tick();
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011;
        d_addr_i = 32'h200; d_wdata_i = 32'hAABB_CCDD;
        d_q.push_back(last_d);
        sample();
        check("wr_we",    32'(ram_we_o), 32'h1);
        check("wr_be",    32'(ram_be_o), 32'h3);
        check("wr_wdata", ram_wdata_o, 32'hAABB_CCDD);
        check("wr_addr",  32'(ram_addr_o), 32'h200);
        tick();
        d_we_i = 1'b0; d_be_i = 4'h0; d_wdata_i = 32'h0;
        d_q.push_back(32'h1122_CCDD);
        sample();
        check("wr_valid",   32'(d_valid_o), 32'h1);
        check("rd_ce",      32'(ram_ce_o), 32'h1);
        check("rd_we",      32'(ram_we_o), 32'h0);
        tick(); d_req_i = 1'b0;
        sample();
        check("rd_valid",   32'(d_valid_o), 32'h1);
        tick(); sample();
        check("rd_once",    32'(d_valid_o), 32'h0);
        last_d = 32'h1122_CCDD;

        // Flush squashes the IF return and blocks IF for that cycle
        tick(); if_req_i = 1'b1; if_addr_i = 32'hC;
        sample();
        check("fl_grant",  32'(ram_addr_o), 32'hC);
        tick(); flush_jump_i = 1'b1; if_addr_i = 32'h20;
        sample();
        check("fl_valid",  32'(if_valid_o), 32'h0);
        check("fl_inst",   if_inst_o, last_if);
        check("fl_no_ce",  32'(ram_ce_o), 32'h0);
        tick(); flush_jump_i = 1'b0; if_q.push_back(mem[8]);
        sample();
        check("fl_ce2",    32'(ram_ce_o), 32'h1);
        check("fl_addr2",  32'(ram_addr_o), 32'h20);
        tick(); if_req_i = 1'b0;
        sample();
        check("fl_valid3", 32'(if_valid_o), 32'h1);
        last_if = mem[8];
        tick(); sample();

        // Asynchronous reset between grant and return
        tick(); if_req_i = 1'b1; if_addr_i = 32'h4;
        sample();
        check("ar_grant",  32'(ram_ce_o), 32'h1);
        check("ar_pre",    if_inst_o, last_if);
        #1 rst_i = 1'b1;
        #1;
        check("ar_ce",     32'(ram_ce_o), 32'h0);
        check("ar_ifv",    32'(if_valid_o), 32'h0);
        check("ar_dv",     32'(d_valid_o), 32'h0);
        check("ar_inst",   if_inst_o, 32'h0);
        check("ar_rdata",  d_rdata_o, 32'h0);
        tick(); if_req_i = 1'b0;
        tick(); rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); sample();
            check("ar_no_ifv", 32'(if_valid_o), 32'h0);
            check("ar_no_dv",  32'(d_valid_o), 32'h0);
        end

        check("if_q_empty", 32'(if_q.size()), 32'h0);
        check("d_q_empty",  32'(d_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Pipelined arbiter that shares one synchronous single-port RAM between the instruction-fetch stage and the MEM stage of the 5-stage core. It sits between `pc_reg`/`if_id` and `mem` on one side and the RAM on the other. It grants at most one access per cycle and routes read data back to the owner one cycle later. It raises per-stage stall requests toward `pipe_ctrl` while a requester is waiting.

## Interface
- ADDR_WIDTH, 32, byte address width of both requesters
- DATA_WIDTH, 32, data word width
- RAM_ADDR_WIDTH, 21, byte address bits forwarded to RAM (upper bits dropped)
- MAX_D_BURST, 4, consecutive data grants allowed while IF is pending (1..15)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_jump_i  in  1  from `pipe_ctrl`: discard in-flight/pending IF access
- if_req_i  in  1  instruction read request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_inst_o  out  DATA_WIDTH  fetched word, held until next IF return
- if_valid_o  out  1  one-cycle pulse: if_inst_o is new
- d_req_i  in  1  data access request
- d_we_i  in  1  1 = write, 0 = read
- d_be_i  in  4  byte enables for writes
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  write data
- d_rdata_o  out  DATA_WIDTH  read data, held until next data read return
- d_valid_o  out  1  one-cycle pulse: read data returned or write done
- stallreq_if_o  out  1  to `pipe_ctrl`
- stallreq_mem_o  out  1  to `pipe_ctrl`
- ram_ce_o, ram_we_o  out  1  RAM access strobe / write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  RAM_ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

## Operation
- Requester protocol: hold req, addr, we, be and wdata stable until the matching valid pulse. A req still high in the cycle after valid is a new request.
- Per-requester `issued` flag: set on grant, cleared on valid. A requester with `issued`=1 is never granted again.
- Grant (combinational, issue cycle): candidates are requesters with req=1 and issued=0.
  - Data wins a tie unless burst_cnt == MAX_D_BURST, in which case IF wins.
  - ram_* outputs are driven from the winner. All ram_* outputs are 0 when there is no grant.
- burst_cnt (4 bits):
  - Increments on a data grant while an IF candidate was denied.
  - Clears on an IF grant or when IF has no pending request.
  - Saturates at MAX_D_BURST.
- Response stage: registers resp_valid and resp_owner (IF/D) and resp_we at each grant.
  - Next cycle, if owner=IF: if_inst_o <= ram_rdata_i and if_valid_o=1.
  - If owner=D read: d_rdata_o <= ram_rdata_i and d_valid_o=1.
  - If owner=D write: d_valid_o=1 and d_rdata_o is unchanged.
- Throughput is one access per cycle: a new grant may issue in the same cycle a response returns.
- Stall: stallreq_x_o = x_req_i & ~x_valid_o.
- Flush:
  - Clears IF `issued`.
  - Squashes an IF response due next cycle: if_valid_o stays 0 and if_inst_o is unchanged.
  - IF is not granted in the flush cycle.
  - Data accesses are unaffected.
- Re-reads or re-writes caused by a requester holding the same request after valid are legal and idempotent.

## Timing
- Reset (asynchronous): if_inst_o, d_rdata_o, if_valid_o, d_valid_o, burst_cnt, the issued flags and resp_valid are all 0. Stall outputs follow the req inputs combinationally; with req=0 they are 0.
- Read latency: grant in cycle T, then valid and data in cycle T+1.
- Write: RAM write occurs at the end of T; d_valid_o is asserted in T+1.
- Simultaneous return and new request from the same requester in T+1: the new request may be granted in T+1 (issued was cleared by the valid).
- Reset asserted mid-access: any in-flight response is dropped and no valid pulse follows.

## Test plan
- IF only: if_req_i=1, addr 0x0, RAM[0]=0x00000013. Required: ram_ce_o in cycle 0, if_valid_o and if_inst_o=0x13 in cycle 1, stallreq_if_o=1 in cycle 0 only.
- Conflict: both requesting in the same cycle, d read 0x100=0xDEADBEEF. Required: data granted first, d_valid_o in cycle 1, IF granted in cycle 1, if_valid_o in cycle 2.
- Starvation: d_req_i held with a new request after every valid, MAX_D_BURST=4, IF pending. Required: IF granted on the 5th grant cycle, burst_cnt back to 0.
- Write then read: write 0x200 with be=0011 and data 0xAABBCCDD over old value 0x11223344. Next read returns 0x1122CCDD; d_valid_o pulses once per access.
- Flush: IF granted in T and flush_jump_i=1 in T+1. Required: if_valid_o=0 in T+1, if_inst_o unchanged, new IF address granted in T+2.
- Async reset asserted between grant and return. Required: all outputs 0 immediately, no valid pulse after release.
